// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_slave
//  Purpose  : SPI mode-0 responder that decodes a flash-like byte command
//             protocol (0x02 write, 0x03 read, 0x9F read-ID) and exposes a
//             byte-wide register read/write port with address auto-increment.
//  Option   : define SPI_REG_SLAVE_FAST_READ_EN to accept 0x0B fast read
//             (address byte, one dummy byte, then read data).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_slave #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic              clk_in_clk,
  input  logic              reset_reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_SS_n,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  output logic              reg_wr_strobe,
  output logic              reg_rd_strobe,
  input  logic [7:0]        reg_rd_data
);

  localparam logic [7:0]        C_CMD_WRITE = 8'h02;
  localparam logic [7:0]        C_CMD_READ  = 8'h03;
  localparam logic [7:0]        C_CMD_RDID  = 8'h9F;
`ifdef SPI_REG_SLAVE_FAST_READ_EN
  localparam logic [7:0]        C_CMD_FREAD = 8'h0B;
`endif
  localparam logic [ADDR_W-1:0] C_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef SPI_REG_SLAVE_FAST_READ_EN
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_WADDR, S_WDATA, S_RADDR, S_RDATA, S_ID, S_IGNORE,
    S_FADDR, S_RDUMMY
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_WADDR, S_WDATA, S_RADDR, S_RDATA, S_ID, S_IGNORE
  } state_t;
`endif

  // Synchroniser chains: [0],[1] are the two sync stages, [2] is history.
  logic [2:0] sclk_pipe_q, sclk_pipe_d;
  logic [2:0] mosi_pipe_q, mosi_pipe_d;
  logic [2:0] ss_pipe_q,   ss_pipe_d;
  // Marks when the SS_n chain reflects the pin rather than its reset value.
  logic [1:0] sync_vld_q,  sync_vld_d;
  // Set once SS_n has been seen high since reset, so a select that was
  // already active during reset never starts a transaction.
  logic       armed_q,     armed_d;

  state_t              state_q,   state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          rx_q,      rx_d;
  logic [7:0]          tx_q,      tx_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                wr_stb_q,  wr_stb_d;
  logic                rd_stb_q,  rd_stb_d;
  logic                rd_pend_q, rd_pend_d;

  logic       sclk_rise;
  logic       sclk_fall;
  logic       mosi_bit;
  logic       ss_n_sync;
  logic       ss_fall;
  logic       byte_done;
  logic [7:0] rx_byte;

  assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign mosi_bit  = mosi_pipe_q[2];
  assign ss_n_sync = ss_pipe_q[1];
  assign ss_fall   = armed_q & ~ss_pipe_q[1] & ss_pipe_q[2];
  assign rx_byte   = {rx_q, mosi_bit};

  // Next values of the pin synchronisers and the select-arming flag.
  always_comb begin
    sclk_pipe_d = {sclk_pipe_q[1:0], spi_SCLK};
    mosi_pipe_d = {mosi_pipe_q[1:0], spi_MOSI};
    ss_pipe_d   = {ss_pipe_q[1:0],   spi_SS_n};
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    armed_d     = armed_q | (sync_vld_q[1] & ss_n_sync);
  end

  // Command decoder, shifters, address handling and strobe generation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    rd_pend_d = rd_stb_q;
    byte_done = 1'b0;

    // The written address stays on reg_addr during the strobe, then advances.
    if (wr_stb_q) begin
      addr_d = addr_q + C_ADDR_ONE;
    end

    if (state_q == S_IDLE) begin
      if (ss_fall) begin
        state_d   = S_CMD;
        bit_cnt_d = 3'd0;
        tx_d      = 8'h00;
      end
    end else if (ss_n_sync) begin
      // Deselect wins over everything, including a byte finishing now.
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
      end

      // A counter of 0 means the MSB of a freshly loaded byte is on MISO and
      // must survive the trailing fall of the previous byte.
      if (sclk_fall && (bit_cnt_q != 3'd0) &&
          ((state_q == S_RDATA) || (state_q == S_ID))) begin
        tx_d = {tx_q[6:0], 1'b0};
      end

      if (byte_done) begin
        case (state_q)
          S_CMD: begin
            case (rx_byte)
              C_CMD_WRITE: state_d = S_WADDR;
              C_CMD_READ:  state_d = S_RADDR;
              C_CMD_RDID: begin
                state_d = S_ID;
                tx_d    = DEVICE_ID;
              end
`ifdef SPI_REG_SLAVE_FAST_READ_EN
              C_CMD_FREAD: state_d = S_FADDR;
`endif
              default:     state_d = S_IGNORE;
            endcase
          end
          S_WADDR: begin
            addr_d  = rx_byte[ADDR_W-1:0];
            state_d = S_WDATA;
          end
          S_WDATA: begin
            wr_data_d = rx_byte;
            wr_stb_d  = 1'b1;
          end
          S_RADDR: begin
            addr_d   = rx_byte[ADDR_W-1:0];
            rd_stb_d = 1'b1;
            state_d  = S_RDATA;
          end
`ifdef SPI_REG_SLAVE_FAST_READ_EN
          // First fetch is issued now so data is ready after the dummy byte.
          S_FADDR: begin
            addr_d   = rx_byte[ADDR_W-1:0];
            rd_stb_d = 1'b1;
            state_d  = S_RDUMMY;
          end
          S_RDUMMY: begin
            state_d = S_RDATA;
          end
`endif
          S_RDATA: begin
            addr_d   = addr_q + C_ADDR_ONE;
            rd_stb_d = 1'b1;
          end
          S_ID: begin
            tx_d = DEVICE_ID;
          end
          default: begin
          end
        endcase
      end
    end

    // Register-file data arrives the cycle after the read strobe.
    if (rd_pend_q) begin
      tx_d = reg_rd_data;
    end
  end

  // State register for the synchronisers, FSM and datapath.
  always_ff @(posedge clk_in_clk) begin
    if (!reset_reset_n) begin
      sclk_pipe_q <= 3'b000;
      mosi_pipe_q <= 3'b000;
      ss_pipe_q   <= 3'b111;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      wr_data_q   <= 8'h00;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      ss_pipe_q   <= ss_pipe_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign spi_MISO_oe   = ~ss_n_sync;
  assign spi_MISO      = ~ss_n_sync & tx_q[7] &
                         ((state_q == S_RDATA) || (state_q == S_ID));
  assign reg_addr      = addr_q;
  assign reg_wr_data   = wr_data_q;
  assign reg_wr_strobe = wr_stb_q;
  assign reg_rd_strobe = rd_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_slave
//  Purpose  : Self-checking bench for spi_reg_slave (table vectors, corner
//             sequences and randomized transactions against a byte-level model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

  localparam int HALF = 6;  // SCLK half period in clk cycles (12x ratio)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi, ss_n;
  logic       miso, miso_oe;
  logic [7:0] addr, wr_data;
  logic       wr_stb, rd_stb;
  logic [7:0] rd_data = 8'h00;

  always #5 clk = ~clk;

  spi_reg_slave dut (
    .clk_in_clk    (clk),
    .reset_reset_n (rst_n),
    .spi_SCLK      (sclk),
    .spi_MOSI      (mosi),
    .spi_SS_n      (ss_n),
    .spi_MISO      (miso),
    .spi_MISO_oe   (miso_oe),
    .reg_addr      (addr),
    .reg_wr_data   (wr_data),
    .reg_wr_strobe (wr_stb),
    .reg_rd_strobe (rd_stb),
    .reg_rd_data   (rd_data)
  );

  // Register file model with one-cycle read latency, plus strobe logging.
  logic [7:0]  mem [256];
  logic        mem_init = 1'b0;
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  logic        prev_stb = 1'b0;
  int          back_to_back = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= ~8'(a);
    end else if (wr_stb) begin
      mem[addr] <= wr_data;
    end
    if (rd_stb) rd_data <= mem[addr];
    if (wr_stb) wr_log.push_back({addr, wr_data});
    if (rd_stb) rd_log.push_back(addr);
    if ((wr_stb | rd_stb) && prev_stb) back_to_back++;
    prev_stb <= wr_stb | rd_stb;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string what, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", what, idx, got, exp);
    end
  endtask

  // SPI master side
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      r = {r[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input int n, input int extra_bits);
    logic [7:0] junk;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < n; k++) spi_bits(tx_buf[k], 8, rx_buf[k]);
    if (extra_bits > 0) spi_bits(8'hFF, extra_bits, junk);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Byte-level reference model of a whole transaction.
  logic [7:0]  exp_miso [8];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  task automatic model(input int n);
    logic [7:0] a;
    exp_wr.delete();
    exp_rd.delete();
    for (int k = 0; k < 8; k++) exp_miso[k] = 8'h00;
    a = tx_buf[1];
    case (tx_buf[0])
      8'h02: for (int k = 2; k < n; k++) exp_wr.push_back({a + 8'(k - 2), tx_buf[k]});
      8'h03: begin
        for (int k = 1; k < n; k++) exp_rd.push_back(a + 8'(k - 1));
        for (int k = 2; k < n; k++) exp_miso[k] = mem[a + 8'(k - 2)];
      end
      8'h9F: for (int k = 1; k < n; k++) exp_miso[k] = 8'hA5;
`ifdef SPI_REG_SLAVE_FAST_READ_EN
      8'h0B: begin
        if (n >= 2) exp_rd.push_back(a);
        for (int k = 3; k < n; k++) exp_rd.push_back(a + 8'(k - 2));
        for (int k = 3; k < n; k++) exp_miso[k] = mem[a + 8'(k - 3)];
      end
`endif
      default: ;
    endcase
  endtask

  task automatic check_txn(input string tag, input int n);
    for (int k = 0; k < n; k++) cmp({tag, ".miso"}, k, 32'(rx_buf[k]), 32'(exp_miso[k]));
    cmp({tag, ".nwr"}, 0, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      cmp({tag, ".wr"}, i, 32'(wr_log[i]), 32'(exp_wr[i]));
    cmp({tag, ".nrd"}, 0, 32'(rd_log.size()), 32'(exp_rd.size()));
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      cmp({tag, ".rd"}, i, 32'(rd_log[i]), 32'(exp_rd[i]));
    wr_log.delete();
    rd_log.delete();
  endtask

  function automatic logic [31:0] outs_now();
    return {13'd0, miso, miso_oe, addr, wr_data, wr_stb, rd_stb};
  endfunction

  // Directed vectors: bytes and expected MISO listed last-byte-first.
  typedef struct packed {
    logic [3:0]       n;
    logic [5:0][7:0]  b;
    logic [5:0][7:0]  miso;
    logic [3:0]       nwr;
    logic [1:0][15:0] wr;
    logic [3:0]       nrd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] junk;
    int         n;
    int         sel;

    vecs[0] = '{n: 4, b: {16'h0, 8'hC3, 8'h5A, 8'h10, 8'h02}, miso: '0,
                nwr: 2, wr: {16'h11C3, 16'h105A}, nrd: 0};
    vecs[1] = '{n: 4, b: {16'h0, 8'h00, 8'h00, 8'hFF, 8'h03},
                miso: {16'h0, 8'hFF, 8'h00, 8'h00, 8'h00}, nwr: 0, wr: '0, nrd: 3};
    vecs[2] = '{n: 4, b: {16'h0, 8'h00, 8'h00, 8'h00, 8'h9F},
                miso: {16'h0, 8'hA5, 8'hA5, 8'hA5, 8'h00}, nwr: 0, wr: '0, nrd: 0};
    vecs[3] = '{n: 3, b: {24'h0, 8'h34, 8'h12, 8'h77}, miso: '0,
                nwr: 0, wr: '0, nrd: 0};
`ifdef SPI_REG_SLAVE_FAST_READ_EN
    vecs[4] = '{n: 4, b: {16'h0, 8'h00, 8'h00, 8'h04, 8'h0B},
                miso: {16'h0, 8'hFB, 8'h00, 8'h00, 8'h00}, nwr: 0, wr: '0, nrd: 2};
`else
    vecs[4] = '{n: 4, b: {16'h0, 8'h00, 8'h00, 8'h04, 8'h0B}, miso: '0,
                nwr: 0, wr: '0, nrd: 0};
`endif

    // Reset state
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; mem_init = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_outputs", 0, outs_now(), 32'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wr_log.delete();
    rd_log.delete();

    // Table-driven directed transactions
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 6; k++) tx_buf[k] = vecs[v].b[k];
      run_txn(int'(vecs[v].n), 0);
      for (int k = 0; k < int'(vecs[v].n); k++)
        cmp("vec.miso", v * 10 + k, 32'(rx_buf[k]), 32'(vecs[v].miso[k]));
      cmp("vec.nwr", v, 32'(wr_log.size()), 32'(vecs[v].nwr));
      for (int i = 0; i < int'(vecs[v].nwr) && i < wr_log.size(); i++)
        cmp("vec.wr", v * 10 + i, 32'(wr_log[i]), 32'(vecs[v].wr[i]));
      cmp("vec.nrd", v, 32'(rd_log.size()), 32'(vecs[v].nrd));
      wr_log.delete();
      rd_log.delete();
    end

    // Abort mid-byte: partial data byte must not write
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h20;
    run_txn(2, 5);
    cmp("abort.nwr", 0, 32'(wr_log.size()), 32'd0);
    wr_log.delete();
    rd_log.delete();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h20; tx_buf[2] = 8'h01;
    model(3);
    run_txn(3, 0);
    check_txn("after_abort", 3);

    // Reset mid-transfer with SS_n held low and SCLK toggling
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(8'h02, 3, junk);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("midreset_outputs", 0, outs_now(), 32'd0);
    spi_bits(8'h40, 4, junk);
    cmp("midreset_outputs", 1, outs_now(), 32'd0);
    rst_n = 1'b1;
    spi_bits(8'h02, 8, junk);
    spi_bits(8'h40, 8, junk);
    spi_bits(8'h99, 8, junk);
    cmp("postreset_miso", 0, 32'(miso), 32'd0);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
    cmp("postreset_nstb", 0, 32'(wr_log.size() + rd_log.size()), 32'd0);
    wr_log.delete();
    rd_log.delete();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h30; tx_buf[2] = 8'h77;
    model(3);
    run_txn(3, 0);
    check_txn("first_after_reset", 3);

    // Randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      sel = int'($urandom_range(0, 4));
      n   = int'($urandom_range(2, 6));
      for (int k = 0; k < 8; k++) tx_buf[k] = 8'($urandom);
      case (sel)
        0: tx_buf[0] = 8'h02;
        1: tx_buf[0] = 8'h03;
        2: tx_buf[0] = 8'h9F;
        3: tx_buf[0] = 8'h0B;
        default: ;
      endcase
      model(n);
      run_txn(n, 0);
      check_txn("rand", n);
    end

    cmp("strobe_spacing", 0, 32'(back_to_back), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
